// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed
// 7-segment scan controller.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Segment order {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    s = SEG_BLANK;
    unique case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h18;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h27;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hex7seg.sv
// Combinational hex-to-7-segment decoder shared by
// all scanned digits.
module seg7_scan_ctrl_hex7seg
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_decode(nib_i);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode
// 7-segment display with frame-aligned double buffering.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIV        = 50000,
  parameter int unsigned DEAD       = 2,
  parameter bit          BLANK_LZ   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned CW = cnt_width(DIV);
  localparam int unsigned IW = cnt_width(NUM_DIGITS);
  localparam int unsigned NW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]         div_cnt_q, div_cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NW-1:0]         act_q, act_d;
  logic [NW-1:0]         pend_w_q, pend_w_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pend_q, pend_d;
  logic                  wrap;

  logic [3:0]            nib;
  logic [6:0]            hex_seg;
  logic [NUM_DIGITS-1:0] lz;
  logic                  lz_run;
  logic                  lit;
  logic                  blank_dig;

  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fd_q;

  always_comb begin
    div_cnt_d = div_cnt_q;
    idx_d     = idx_q;
    wrap      = 1'b0;
    if (!en) begin
      div_cnt_d = '0;
      idx_d     = '0;
    end else if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
        wrap  = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      div_cnt_d = div_cnt_q + CW'(1);
    end
  end

  // A load on the wrap edge bypasses pending so it lands
  // in the frame that starts on that same edge.
  always_comb begin
    act_d     = act_q;
    act_dp_d  = act_dp_q;
    pend_w_d  = pend_w_q;
    pend_dp_d = pend_dp_q;
    pend_d    = pend_q;
    if (load) begin
      pend_w_d  = data_in;
      pend_dp_d = dp_in;
      pend_d    = 1'b1;
    end
    if (wrap) begin
      if (load) begin
        act_d    = data_in;
        act_dp_d = dp_in;
        pend_d   = 1'b0;
      end else if (pend_q) begin
        act_d    = pend_w_q;
        act_dp_d = pend_dp_q;
        pend_d   = 1'b0;
      end
    end
  end

  always_comb begin
    lz     = '0;
    lz_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lz_run = lz_run && (act_q[4*i +: 4] == 4'h0)
               && !act_dp_q[i];
      lz[i]  = lz_run;
    end
  end

  assign nib = act_q[{idx_q, 2'b00} +: 4];

  seg7_scan_ctrl_hex7seg u_hex (
    .nib_i (nib),
    .seg_o (hex_seg)
  );

  assign lit       = en && (32'(div_cnt_q) >= DEAD);
  assign blank_dig = BLANK_LZ && lz[idx_q];

  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    an_d  = '1;
    if (lit) begin
      an_d[idx_q] = 1'b0;
      seg_d       = blank_dig ? SEG_BLANK : hex_seg;
      dp_d        = ~act_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      idx_q     <= '0;
      act_q     <= '0;
      act_dp_q  <= '0;
      pend_w_q  <= '0;
      pend_dp_q <= '0;
      pend_q    <= 1'b0;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
      an_q      <= '1;
      fd_q      <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      act_q     <= act_d;
      act_dp_q  <= act_dp_d;
      pend_w_q  <= pend_w_d;
      pend_dp_q <= pend_dp_d;
      pend_q    <= pend_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
      fd_q      <= wrap;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with 4 digits,
// 4-cycle slots and 1 dead cycle.
module tb_seg7_scan_ctrl;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b1;
  logic        load  = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in   = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg7_scan_ctrl #(
    .NUM_DIGITS (4),
    .DIV        (4),
    .DEAD       (1),
    .BLANK_LZ   (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] a,
                         input logic [6:0] s, input logic d,
                         input logic f);
    chk({tag, ".an"},  32'(an),         32'(a));
    chk({tag, ".seg"}, 32'(seg),        32'(s));
    chk({tag, ".dp"},  32'(dp),         32'(d));
    chk({tag, ".fd"},  32'(frame_done), 32'(f));
  endtask

  task automatic dark(input string tag);
    chk_out(tag, 4'hF, 7'h7F, 1'b1, 1'b0);
  endtask

  task automatic wait_fd(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (frame_done !== 1'b1 && n < 40);
    chk(tag, 32'(frame_done), 32'd1);
  endtask

  // Checks one full frame starting just after a wrap edge;
  // optional loads are captured on edge k of the frame.
  task automatic frame(input string tag,
                       input logic [6:0] e0, input logic [6:0] e1,
                       input logic [6:0] e2, input logic [6:0] e3,
                       input logic [3:0] edp,
                       input int k1, input logic [15:0] w1,
                       input logic [3:0] d1,
                       input int k2, input logic [15:0] w2,
                       input logic [3:0] d2);
    logic [6:0] es [4];
    es[0] = e0;
    es[1] = e1;
    es[2] = e2;
    es[3] = e3;
    for (int k = 1; k <= 16; k++) begin
      int s;
      int p;
      string t;
      if (k == k1) begin
        load = 1'b1; data_in = w1; dp_in = d1;
      end else if (k == k2) begin
        load = 1'b1; data_in = w2; dp_in = d2;
      end
      tick();
      load = 1'b0;
      s = (k - 1) / 4;
      p = (k - 1) % 4;
      t = $sformatf("%s.k%0d", tag, k);
      if (p == 0)
        chk_out(t, 4'hF, 7'h7F, 1'b1, 1'b0);
      else
        chk_out(t, ~(4'b0001 << s), es[s], edp[s], k == 16);
    end
  endtask

  initial begin
    tick();
    dark("rst0");
    tick();
    dark("rst1");
    rst_n = 1'b1;
    tick();
    dark("rel1");
    tick();
    chk_out("first_lit", 4'hE, 7'h40, 1'b1, 1'b0);

    load = 1'b1; data_in = 16'h12AF; dp_in = 4'b0100;
    tick();
    load = 1'b0;
    wait_fd("fd_a");

    frame("f12AF", 7'h0E, 7'h08, 7'h24, 7'h79, 4'b1011,
          3, 16'h1111, 4'h0, 7, 16'h2222, 4'h0);
    frame("f2222", 7'h24, 7'h24, 7'h24, 7'h24, 4'hF,
          16, 16'h0050, 4'h0, 0, 16'h0, 4'h0);
    frame("f0050", 7'h40, 7'h12, 7'h7F, 7'h7F, 4'hF,
          5, 16'h0000, 4'h0, 0, 16'h0, 4'h0);
    frame("f0000", 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'hF,
          8, 16'h0000, 4'b1000, 0, 16'h0, 4'h0);
    frame("fdp3", 7'h40, 7'h40, 7'h40, 7'h40, 4'b0111,
          0, 16'h0, 4'h0, 0, 16'h0, 4'h0);

    repeat (6) tick();
    chk_out("pre_off", 4'hD, 7'h40, 1'b1, 1'b0);
    en = 1'b0;
    tick();
    dark("off1");
    repeat (3) tick();
    dark("off4");
    en = 1'b1;
    tick();
    dark("on1");
    tick();
    chk_out("on2", 4'hE, 7'h40, 1'b1, 1'b0);

    load = 1'b1; data_in = 16'h1234; dp_in = 4'hF;
    tick();
    load = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    dark("arst");
    tick();
    dark("arst_hold");
    rst_n = 1'b1;
    tick();
    dark("rrel1");
    tick();
    chk_out("rrel2", 4'hE, 7'h40, 1'b1, 1'b0);
    repeat (3) tick();
    dark("rrel5");
    tick();
    chk_out("rrel6", 4'hD, 7'h7F, 1'b1, 1'b0);
    wait_fd("fd_b");
    frame("fclr", 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'hF,
          0, 16'h0, 4'h0, 0, 16'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. It holds a NUM_DIGITS-nibble display word and cycles one shared hex decoder across the digits, driving one active-low anode at a time with dead-time between digits. New values are double-buffered and applied only at frame boundaries, so a frame never shows a mix of old and new digits. It sits between the counter/BCD datapath and the board's segment/anode pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned (2..8)
- DIV, 50000, clock cycles per digit slot (≥ DEAD+1)
- DEAD, 2, blank cycles at the start of each slot (≥ 0)
- BLANK_LZ, 1, 1 = suppress leading zeros
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  scan enable; 0 = display dark, counters held at 0
- load  in  1  single-cycle strobe: capture data_in/dp_in
- data_in  in  4*NUM_DIGITS  display word, nibble i = digit i (digit 0 = least significant)
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- an  out  NUM_DIGITS  digit anodes, active-low, at most one low
- frame_done  out  1  one-cycle pulse at each frame wrap

## Operation
- Registers: div_cnt (0..DIV-1), idx (0..NUM_DIGITS-1), active word/dp, pending word/dp, pend flag.
- Reset: div_cnt=0, idx=0, active/pending=0, pend=0; an=all 1s, seg=7'h7F, dp=1, frame_done=0.
- en=1: div_cnt increments; at DIV-1 it wraps to 0 and idx advances; idx NUM_DIGITS-1→0 is the frame wrap.
- en=0: div_cnt and idx forced to 0, outputs dark (an all 1s, seg 7'h7F, dp 1); load still captures into pending.
- load: data_in/dp_in → pending, pend=1; multiple loads before a wrap: last one wins.
- Frame wrap edge: if pend, active←pending, pend←0; frame_done=1 for that cycle.
- load on the wrap edge: data_in goes directly to active, pend←0.
- Slot output: div_cnt<DEAD → an all 1s, seg 7'h7F, dp 1; else an[idx]=0, seg = decode(active nibble idx), dp = ~active_dp[idx].
- Decode, hex 0..F: 40,79,24,30,19,12,02,78,00,18,08,03,27,21,06,0E.
- Leading-zero blank (BLANK_LZ=1): digit i>0 shows seg=7'h7F (anode still driven) when nibbles NUM_DIGITS-1..i are all zero and dp_in of those digits is 0; digit 0 is never blanked.

## Timing
- seg/dp/an registered: reflect the div_cnt/idx/active values from the previous cycle (1-cycle latency).
- Slot = DIV cycles: DEAD dark + (DIV-DEAD) lit; frame = NUM_DIGITS*DIV cycles.
- First lit output after reset release with en=1: cycle DEAD+1, digit 0.
- Active updates take effect on the first slot of the new frame; latency from load ≤ one frame + 1 cycle.
- Reset mid-frame: immediate dark outputs; pending data lost.
- en falling: outputs dark on next cycle; en rising: scan restarts at digit 0, div_cnt 0; no frame_done pulse on restart.

## Structure
- Package seg7_pkg: segment encoding constants (SEG_BLANK=7'h7F), hex decode function or table, digit-index width function.
- One sub-module: the team's existing hex7seg decoder, instantiated once and fed the nibble selected by idx; blanking mux after it.

## Test plan
- Reset with en=1 (NUM_DIGITS=4, DIV=4, DEAD=1): an=4'hF, seg=7'h7F, dp=1, frame_done=0 during and 1 cycle after reset.
- load 16'h12AF, dp_in=4'b0100 → after next frame_done, digit 0 seg=7'h0E, digit 1 7'h08, digit 2 7'h24 with dp=0, digit 3 7'h79; each digit lit 3 cycles after 1 dark cycle; never two anodes low.
- BLANK_LZ=1, load 16'h0050 → digits 3,2 seg=7'h7F, digit 1 7'h12, digit 0 7'h40; load 16'h0000 → only digit 0 shows 7'h40.
- Two loads mid-frame (16'h1111 then 16'h2222) → current frame unchanged; next frame all digits 7'h24.
- load coinciding with the frame-wrap edge → new value displayed in the frame that starts on that edge; pend=0 afterwards.
- Drop en mid-slot → dark next cycle; raise en → digit 0 after DEAD cycles; assert rst_n low mid-frame → immediate dark, old active word cleared to 0.
